// File: rtl/bp_cfg_mc.sv
// bp_cfg_mc: configuration-bus master controller.
// Accepts config commands, serves the local freeze/cce_mode registers, forwards
// remote accesses as single-cycle strobes, and returns one in-order response
// per accepted command through a small credit-managed FIFO.
module bp_cfg_mc #(
    parameter int num_core_p       = 4,
    parameter int cfg_addr_width_p = 16,
    parameter int cfg_data_width_p = 64,
    parameter int read_latency_p   = 2,
    parameter int fifo_els_p       = 4
) (
    input  logic                                     clk_i,
    input  logic                                     reset_n_i,

    input  logic                                     mem_cmd_v_i,
    output logic                                     mem_cmd_ready_o,
    input  logic                                     mem_cmd_wr_i,
    input  logic [cfg_addr_width_p-1:0]              mem_cmd_addr_i,
    input  logic [cfg_data_width_p-1:0]              mem_cmd_data_i,
    input  logic [3:0]                               mem_cmd_core_i,

    output logic                                     mem_resp_v_o,
    input  logic                                     mem_resp_yumi_i,
    output logic [cfg_data_width_p-1:0]              mem_resp_data_o,
    output logic                                     mem_resp_wr_o,
    output logic                                     mem_resp_err_o,

    output logic [num_core_p-1:0]                    freeze_o,
    output logic [num_core_p-1:0]                    cce_mode_o,

    output logic                                     cfg_w_v_o,
    output logic                                     cfg_r_v_o,
    output logic [num_core_p-1:0]                    cfg_core_sel_o,
    output logic [cfg_addr_width_p-1:0]              cfg_addr_o,
    output logic [cfg_data_width_p-1:0]              cfg_data_o,

    input  logic [num_core_p*cfg_data_width_p-1:0]   rd_data_i
);

    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);
    localparam int ptr_w_lp = $clog2(fifo_els_p);

    // Credit counter: commands accepted but whose response has not been consumed.
    logic [cnt_w_lp-1:0]         credit_cnt_r;
    logic                        accept;
    logic                        yumi;

    // Command decode results.
    logic                        is_freeze;
    logic                        is_cce;
    logic                        is_remote;
    logic                        is_bcast;
    logic                        core_ok;
    logic                        cmd_err;
    logic                        local_bit;

    // Local configuration registers.
    logic [num_core_p-1:0]       freeze_r;
    logic [num_core_p-1:0]       cce_mode_r;

    // Valid/tag pipeline modelling the remote read latency.
    logic [read_latency_p-1:0]   pipe_v_r;
    logic [read_latency_p-1:0]   pipe_wr_r;
    logic [read_latency_p-1:0]   pipe_err_r;
    logic [read_latency_p-1:0]   pipe_remote_r;
    logic [read_latency_p-1:0]   pipe_ldata_r;
    logic [3:0]                  pipe_core_r [read_latency_p];

    logic                        exit_v;
    logic                        exit_wr;
    logic                        exit_err;
    logic                        exit_remote;
    logic                        exit_ldata;
    logic [3:0]                  exit_core;
    logic [cfg_data_width_p-1:0] rd_sel;
    logic [cfg_data_width_p-1:0] resp_data;

    // Response FIFO.
    logic [cfg_data_width_p-1:0] fifo_data_r [fifo_els_p];
    logic [fifo_els_p-1:0]       fifo_wr_r;
    logic [fifo_els_p-1:0]       fifo_err_r;
    logic [ptr_w_lp-1:0]         wr_ptr_r;
    logic [ptr_w_lp-1:0]         rd_ptr_r;
    logic [cnt_w_lp-1:0]         fifo_cnt_r;

    assign mem_cmd_ready_o = reset_n_i && (credit_cnt_r < cnt_w_lp'(fifo_els_p));
    assign accept          = mem_cmd_v_i && mem_cmd_ready_o;
    assign mem_resp_v_o    = (fifo_cnt_r != '0);
    assign yumi            = mem_resp_yumi_i && mem_resp_v_o;

    assign is_freeze = (mem_cmd_addr_i == cfg_addr_width_p'(1));
    assign is_cce    = (mem_cmd_addr_i == cfg_addr_width_p'(4));
    assign is_remote = (mem_cmd_addr_i >= cfg_addr_width_p'(16));
    assign is_bcast  = (mem_cmd_core_i == 4'hF);
    assign core_ok   = ({28'd0, mem_cmd_core_i} < 32'(num_core_p));
    assign cmd_err   = !(is_freeze || is_cce || is_remote)
                     || (!is_bcast && !core_ok)
                     || (is_bcast && !mem_cmd_wr_i);

    assign cfg_w_v_o  = accept && is_remote && !cmd_err && mem_cmd_wr_i;
    assign cfg_r_v_o  = accept && is_remote && !cmd_err && !mem_cmd_wr_i;
    assign cfg_addr_o = mem_cmd_addr_i;
    assign cfg_data_o = mem_cmd_data_i;

    assign freeze_o   = freeze_r;
    assign cce_mode_o = cce_mode_r;

    // One-hot core select, widened to every core on a broadcast write.
    always_comb begin
        cfg_core_sel_o = '0;
        for (int i = 0; i < num_core_p; i++) begin
            cfg_core_sel_o[i] = (is_bcast && mem_cmd_wr_i) || (mem_cmd_core_i == 4'(i));
        end
    end

    // Snapshot of the addressed local register bit, taken in the accept cycle.
    always_comb begin
        local_bit = 1'b0;
        for (int i = 0; i < num_core_p; i++) begin
            if (mem_cmd_core_i == 4'(i)) begin
                local_bit = is_freeze ? freeze_r[i] : cce_mode_r[i];
            end
        end
    end

    // Credit counter tracks accepted-but-unconsumed commands.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credit_cnt_r <= '0;
        end else begin
            case ({accept, yumi})
                2'b10:   credit_cnt_r <= credit_cnt_r + cnt_w_lp'(1);
                2'b01:   credit_cnt_r <= credit_cnt_r - cnt_w_lp'(1);
                default: credit_cnt_r <= credit_cnt_r;
            endcase
        end
    end

    // Local register writes; frozen and uncached out of reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            freeze_r   <= '1;
            cce_mode_r <= '0;
        end else if (accept && !cmd_err && mem_cmd_wr_i) begin
            for (int i = 0; i < num_core_p; i++) begin
                if (is_bcast || (mem_cmd_core_i == 4'(i))) begin
                    if (is_freeze) freeze_r[i]   <= mem_cmd_data_i[0];
                    if (is_cce)    cce_mode_r[i] <= mem_cmd_data_i[0];
                end
            end
        end
    end

    // Tag pipeline: each accepted command rides read_latency_p stages.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pipe_v_r      <= '0;
            pipe_wr_r     <= '0;
            pipe_err_r    <= '0;
            pipe_remote_r <= '0;
            pipe_ldata_r  <= '0;
            for (int k = 0; k < read_latency_p; k++) begin
                pipe_core_r[k] <= '0;
            end
        end else begin
            pipe_v_r[0]      <= accept;
            pipe_wr_r[0]     <= mem_cmd_wr_i;
            pipe_err_r[0]    <= cmd_err;
            pipe_remote_r[0] <= is_remote;
            pipe_ldata_r[0]  <= local_bit;
            pipe_core_r[0]   <= mem_cmd_core_i;
            for (int k = 1; k < read_latency_p; k++) begin
                pipe_v_r[k]      <= pipe_v_r[k-1];
                pipe_wr_r[k]     <= pipe_wr_r[k-1];
                pipe_err_r[k]    <= pipe_err_r[k-1];
                pipe_remote_r[k] <= pipe_remote_r[k-1];
                pipe_ldata_r[k]  <= pipe_ldata_r[k-1];
                pipe_core_r[k]   <= pipe_core_r[k-1];
            end
        end
    end

    assign exit_v      = pipe_v_r[read_latency_p-1];
    assign exit_wr     = pipe_wr_r[read_latency_p-1];
    assign exit_err    = pipe_err_r[read_latency_p-1];
    assign exit_remote = pipe_remote_r[read_latency_p-1];
    assign exit_ldata  = pipe_ldata_r[read_latency_p-1];
    assign exit_core   = pipe_core_r[read_latency_p-1];

    // Pick the remote read data slice belonging to the exiting command's core.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < num_core_p; i++) begin
            if (exit_core == 4'(i)) begin
                rd_sel = rd_data_i[i*cfg_data_width_p +: cfg_data_width_p];
            end
        end
    end

    // Response payload: zero for writes and errors, otherwise remote or local read data.
    always_comb begin
        resp_data = '0;
        if (!exit_err && !exit_wr) begin
            if (exit_remote) begin
                resp_data = rd_sel;
            end else begin
                resp_data[0] = exit_ldata;
            end
        end
    end

    // FIFO storage; contents need no reset since validity lives in the count.
    always_ff @(posedge clk_i) begin
        if (exit_v) begin
            fifo_data_r[wr_ptr_r] <= resp_data;
            fifo_wr_r[wr_ptr_r]   <= exit_wr;
            fifo_err_r[wr_ptr_r]  <= exit_err;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (exit_v) begin
                wr_ptr_r <= (wr_ptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wr_ptr_r + ptr_w_lp'(1);
            end
            if (yumi) begin
                rd_ptr_r <= (rd_ptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rd_ptr_r + ptr_w_lp'(1);
            end
            case ({exit_v, yumi})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + cnt_w_lp'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - cnt_w_lp'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    assign mem_resp_data_o = fifo_data_r[rd_ptr_r];
    assign mem_resp_wr_o   = fifo_wr_r[rd_ptr_r];
    assign mem_resp_err_o  = fifo_err_r[rd_ptr_r];

endmodule
